astra_dac_uart: RTL and testbench
=================================

Name: astra_dac_uart

Overview:
Telemetry poller/bridge. Periodically sends a one-byte request over an RS-485 UART and receives a fixed 14-byte reply frame. Drives the fast-channel byte to DAC1 and a round-robin slow-channel byte to DAC2, both 8-bit parallel. Reports link status on two SKUT lines. Sits between the RS-485 transceiver and two parallel DACs.

Parameters:
BAUD_DIV, 17, clk80 cycles per UART bit (80.64 MHz / 17 ≈ 4.74 Mbaud; peer runs 4.8 Mbaud, 1.2% error allowed).
POLL_DIV, 80640, clk80 cycles between request starts (1 ms).
REQ_BYTE, 8'hA5, request byte transmitted each poll.
FRAME_LEN, 14, bytes per reply frame.
TIMEOUT, 4096, clk80 cycles allowed from receive-enable to frame completion.

Ports:
clk80  in  1  system clock, 80.64 MHz; only clock.
rst_n  in  1  asynchronous active-low reset.
UART0_RX  in  1  RS-485 receive data; idle high.
UART0_TX  out  1  RS-485 transmit data; idle high.
UART0_dTX  out  1  driver enable (DE), active high.
UART0_dRX  out  1  receiver disable (/RE), active high = receiver off.
DAC1_CLK, DAC2_CLK  out  1 each  DAC write strobes.
DAC1_DB0..DAC1_DB7  out  1 each  DAC1 data, DB0 = LSB.
DAC2_DB0..DAC2_DB7  out  1 each  DAC2 data, DB0 = LSB.
DAC_MODE  out  1  DAC interface mode; constant 0.
SKUT_MBR  out  1  link-fault flag.
SKUT_VI  out  1  frame-valid toggle.

Behaviour:
- Reset (async, rst_n=0): UART0_TX=1; dTX=0; dRX=0; all DAC data, DAC clocks and SKUT_* = 0; slot=0; FSM in IDLE; poll counter=0.
- Poll counter is free-running modulo POLL_DIV. At wrap: if FSM is in IDLE, go to TX. Otherwise the poll is skipped.
- TX:
  - dTX=1 and dRX=1 for the whole request byte.
  - Byte is 8N1, LSB first, each bit BAUD_DIV cycles.
  - One cycle after the stop bit ends, dTX=0 and dRX=0, and the FSM goes to RX.
- RX:
  - Start is detected on a 2-flop-synchronised falling edge of RX.
  - Each bit is sampled at BAUD_DIV/2 after its edge, LSB first.
  - Stop bit must read 1; otherwise it is a framing error.
  - Bytes are stored in buf[0..13] by index. The index resets to 0 on entry to RX.
  - Idle gaps between bytes are allowed.
- Frame complete (index reaches FRAME_LEN with no error):
  - Next cycle: DAC1 data = buf[0], DAC2 data = buf[1+slot].
  - slot increments modulo 13 (wraps 12→0).
  - SKUT_VI toggles; SKUT_MBR clears; FSM returns to IDLE.
- DAC strobes: DAC1_CLK and DAC2_CLK go high 1 cycle after the data update and stay high 2 cycles. Data is held stable until the next valid frame.
- Framing error:
  - Abort the frame; set SKUT_MBR=1; leave DAC outputs unchanged; go to IDLE.
  - Bytes after the error are ignored until the next poll.
- Activity on UART0_RX outside RX is ignored.
- Reset mid-frame discards all partial data.

Optional Feature:
ASTRA_FRAME_TIMEOUT_EN:
- Defined: a counter starts on entry to RX. If FRAME_LEN bytes have not arrived within TIMEOUT cycles, abort the frame, set SKUT_MBR=1, return to IDLE, and leave DAC data unchanged.
- Undefined: RX waits indefinitely for FRAME_LEN bytes, and polls are skipped meanwhile.

Test Plan:
1. After reset release → TX=1, dTX=0, dRX=0, all DAC pins 0, SKUT_MBR=0. At first poll wrap, TX shows 0xA5 8N1 with dTX=1 and dRX=1, then dTX and dRX fall together.
2. Reply at 4.8 Mbaud: 0x00,5,10,15,20,25,30,35,40,45,50,55,60,0xED. Expected: DAC1=0x00, DAC2=0x05, DAC clocks pulse 2 cycles, SKUT_VI toggles.
3. Repeat for 14 polls, byte0 = poll number. Expected: DAC1 tracks the poll number; DAC2 steps 5,10,…,60,0xED, then wraps to 5.
4. Stop bit forced 0 in byte 3 → SKUT_MBR=1, DAC data unchanged. Next good frame clears SKUT_MBR.
5. With ASTRA_FRAME_TIMEOUT_EN, send only 10 bytes → after 4096 cycles SKUT_MBR=1, FSM in IDLE, next poll issued. Without the macro, no new request appears.
6. Pulse rst_n low during byte 7 of a reply → outputs return to reset values, and the following full frame is received correctly.

Source files
------------

// File: rtl/astra_dac_uart.sv
// astra_dac_uart -- telemetry poller / DAC bridge.
//
// Every POLL_DIV cycles (if idle) sends REQ_BYTE as 8N1 over RS-485, then
// receives a FRAME_LEN-byte reply. On a clean frame, byte 0 goes to DAC1 and
// a round-robin slow-channel byte (1..FRAME_LEN-1) goes to DAC2, each followed
// by a 2-cycle write strobe. SKUT_VI toggles per good frame; SKUT_MBR flags
// the last frame as faulty (framing error, or timeout when enabled).
//
// Optional feature macro: ASTRA_FRAME_TIMEOUT_EN -- abort the reply if it is
// not complete TIMEOUT cycles after the receiver is enabled.
//
// Ports:
//   clk80, rst_n              clock, asynchronous active-low reset
//   UART0_RX                  RS-485 receive data (idle high)
//   UART0_TX                  RS-485 transmit data (idle high)
//   UART0_dTX / UART0_dRX     driver enable / receiver disable (both high in TX)
//   DAC1_CLK, DAC2_CLK        DAC write strobes
//   DAC1_DB0..7, DAC2_DB0..7  DAC data, DB0 = LSB
//   DAC_MODE                  tied 0
//   SKUT_MBR, SKUT_VI         link-fault flag, frame-valid toggle
module astra_dac_uart #(
  parameter int         BAUD_DIV  = 17,
  parameter int         POLL_DIV  = 80640,
  parameter logic [7:0] REQ_BYTE  = 8'hA5,
  parameter int         FRAME_LEN = 14,
  parameter int         TIMEOUT   = 4096
) (
  input  logic clk80,
  input  logic rst_n,
  input  logic UART0_RX,
  output logic UART0_TX,
  output logic UART0_dTX,
  output logic UART0_dRX,
  output logic DAC1_CLK,
  output logic DAC2_CLK,
  output logic DAC1_DB0, output logic DAC1_DB1, output logic DAC1_DB2, output logic DAC1_DB3,
  output logic DAC1_DB4, output logic DAC1_DB5, output logic DAC1_DB6, output logic DAC1_DB7,
  output logic DAC2_DB0, output logic DAC2_DB1, output logic DAC2_DB2, output logic DAC2_DB3,
  output logic DAC2_DB4, output logic DAC2_DB5, output logic DAC2_DB6, output logic DAC2_DB7,
  output logic DAC_MODE,
  output logic SKUT_MBR,
  output logic SKUT_VI
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(POLL_DIV);
  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int SW = $clog2(FRAME_LEN - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME_LEN - 2);
  // Line image of the request: start bit, data LSB first, stop bit.
  localparam logic [9:0]    TX_FRAME  = {1'b1, REQ_BYTE, 1'b0};
`ifdef ASTRA_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_TX, S_RX} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [BW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic            tx_q, tx_d, dtx_q, dtx_d;
  logic [2:0]      rx_sync_q, rx_sync_d;
  logic            rx_busy_q, rx_busy_d;
  logic [BW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [IW-1:0]   rx_idx_q, rx_idx_d;
  logic            done_q, done_d, stb1_q, stb1_d, stb2_q, stb2_d, dac_clk_q, dac_clk_d;
  logic [7:0]      dac1_q, dac1_d, dac2_q, dac2_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic            mbr_q, mbr_d, vi_q, vi_d;
  logic            buf_we;
  logic [7:0]      buf_q [FRAME_LEN];
`ifdef ASTRA_FRAME_TIMEOUT_EN
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
`endif

  // rx_sync_q[1] is the synchronised line, rx_sync_q[2] its previous value.
  logic rx_in, rx_fall;
  assign rx_in   = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d   = state_q;
    poll_d    = (poll_q == POLL_LAST) ? '0 : poll_q + PW'(1);
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_d      = tx_q;
    dtx_d     = dtx_q;
    rx_sync_d = {rx_sync_q[1:0], UART0_RX};
    rx_busy_d = rx_busy_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_idx_d  = rx_idx_q;
    buf_we    = 1'b0;
    done_d    = 1'b0;
    // Data lands the cycle after done_q; strobe follows one cycle later for 2 cycles.
    stb1_d    = done_q;
    stb2_d    = stb1_q;
    dac_clk_d = stb1_q | stb2_q;
    dac1_d    = dac1_q;
    dac2_d    = dac2_q;
    slot_d    = slot_q;
    mbr_d     = mbr_q;
    vi_d      = vi_q;
`ifdef ASTRA_FRAME_TIMEOUT_EN
    to_cnt_d  = to_cnt_q + TW'(1);
`endif

    unique case (state_q)
      S_IDLE: begin
        // A wrap while busy is simply lost: the poll is skipped.
        if (poll_q == POLL_LAST) begin
          state_d  = S_TX;
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_d     = TX_FRAME[0];
          dtx_d    = 1'b1;
        end
      end
      S_TX: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            state_d   = S_RX;
            dtx_d     = 1'b0;
            tx_d      = 1'b1;
            rx_busy_d = 1'b0;
            rx_idx_d  = '0;
`ifdef ASTRA_FRAME_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_d     = TX_FRAME[tx_bit_q + 4'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + BW'(1);
        end
      end
      S_RX: begin
        if (!rx_busy_q) begin
          if (rx_fall) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = '0;
            rx_bit_d  = '0;
          end
        end else begin
          if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_d = '0;
            rx_bit_d = rx_bit_q + 4'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + BW'(1);
          end
          if (rx_cnt_q == BAUD_HALF) begin
            if (rx_bit_q == 4'd0) begin
              // Line back high mid start bit: a glitch, re-arm for a real edge.
              if (rx_in) rx_busy_d = 1'b0;
            end else if (rx_bit_q != 4'd9) begin
              rx_sh_d = {rx_in, rx_sh_q[7:1]};
            end else begin
              // Stop bit; release the receiver at mid-stop so back-to-back bytes work.
              rx_busy_d = 1'b0;
              if (rx_in) begin
                buf_we = 1'b1;
                if (rx_idx_q == IDX_LAST) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                end else begin
                  rx_idx_d = rx_idx_q + IW'(1);
                end
              end else begin
                mbr_d   = 1'b1;
                state_d = S_IDLE;
              end
            end
          end
        end
`ifdef ASTRA_FRAME_TIMEOUT_EN
        if (to_cnt_q == TO_LAST && !done_d) begin
          mbr_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (done_q) begin
      dac1_d = buf_q[0];
      dac2_d = buf_q[IW'(slot_q) + IW'(1)];
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
      vi_d   = ~vi_q;
      mbr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      poll_q    <= '0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_q      <= 1'b1;
      dtx_q     <= 1'b0;
      rx_sync_q <= 3'b111;
      rx_busy_q <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_idx_q  <= '0;
      done_q    <= 1'b0;
      stb1_q    <= 1'b0;
      stb2_q    <= 1'b0;
      dac_clk_q <= 1'b0;
      dac1_q    <= '0;
      dac2_q    <= '0;
      slot_q    <= '0;
      mbr_q     <= 1'b0;
      vi_q      <= 1'b0;
`ifdef ASTRA_FRAME_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      poll_q    <= poll_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_q      <= tx_d;
      dtx_q     <= dtx_d;
      rx_sync_q <= rx_sync_d;
      rx_busy_q <= rx_busy_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_idx_q  <= rx_idx_d;
      done_q    <= done_d;
      stb1_q    <= stb1_d;
      stb2_q    <= stb2_d;
      dac_clk_q <= dac_clk_d;
      dac1_q    <= dac1_d;
      dac2_q    <= dac2_d;
      slot_q    <= slot_d;
      mbr_q     <= mbr_d;
      vi_q      <= vi_d;
`ifdef ASTRA_FRAME_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  // NOTE: the frame buffer has no reset; every entry read at frame completion
  // was written during that same frame, so stale contents are never visible.
  always_ff @(posedge clk80) begin
    if (buf_we) buf_q[rx_idx_q] <= rx_sh_q;
  end

  assign UART0_TX  = tx_q;
  assign UART0_dTX = dtx_q;
  assign UART0_dRX = dtx_q;
  assign DAC1_CLK  = dac_clk_q;
  assign DAC2_CLK  = dac_clk_q;
  assign {DAC1_DB7, DAC1_DB6, DAC1_DB5, DAC1_DB4, DAC1_DB3, DAC1_DB2, DAC1_DB1, DAC1_DB0} = dac1_q;
  assign {DAC2_DB7, DAC2_DB6, DAC2_DB5, DAC2_DB4, DAC2_DB3, DAC2_DB2, DAC2_DB1, DAC2_DB0} = dac2_q;
  assign DAC_MODE  = 1'b0;
  assign SKUT_MBR  = mbr_q;
  assign SKUT_VI   = vi_q;

endmodule

// File: tb/tb_astra_dac_uart.sv
// Directed bench for astra_dac_uart: request format, good frames with the
// slow-channel rotation, framing error and recovery, missing-bytes behaviour
// (with or without ASTRA_FRAME_TIMEOUT_EN) and reset in the middle of a reply.
module tb_astra_dac_uart;
  localparam int BAUD = 17;
  localparam int POLL = 2800;
  localparam int TMO  = 4096;

  logic clk80 = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic UART0_TX, UART0_dTX, UART0_dRX, DAC1_CLK, DAC2_CLK, DAC_MODE, SKUT_MBR, SKUT_VI;
  logic DAC1_DB0, DAC1_DB1, DAC1_DB2, DAC1_DB3, DAC1_DB4, DAC1_DB5, DAC1_DB6, DAC1_DB7;
  logic DAC2_DB0, DAC2_DB1, DAC2_DB2, DAC2_DB3, DAC2_DB4, DAC2_DB5, DAC2_DB6, DAC2_DB7;
  logic [7:0] dac1, dac2;

  int n_cmp = 0;
  int n_bad = 0;
  int clk1_hi = 0;
  int clk2_hi = 0;

  astra_dac_uart #(.BAUD_DIV(BAUD), .POLL_DIV(POLL), .REQ_BYTE(8'hA5),
                   .FRAME_LEN(14), .TIMEOUT(TMO)) dut (
    .clk80(clk80), .rst_n(rst_n), .UART0_RX(rx),
    .UART0_TX(UART0_TX), .UART0_dTX(UART0_dTX), .UART0_dRX(UART0_dRX),
    .DAC1_CLK(DAC1_CLK), .DAC2_CLK(DAC2_CLK),
    .DAC1_DB0(DAC1_DB0), .DAC1_DB1(DAC1_DB1), .DAC1_DB2(DAC1_DB2), .DAC1_DB3(DAC1_DB3),
    .DAC1_DB4(DAC1_DB4), .DAC1_DB5(DAC1_DB5), .DAC1_DB6(DAC1_DB6), .DAC1_DB7(DAC1_DB7),
    .DAC2_DB0(DAC2_DB0), .DAC2_DB1(DAC2_DB1), .DAC2_DB2(DAC2_DB2), .DAC2_DB3(DAC2_DB3),
    .DAC2_DB4(DAC2_DB4), .DAC2_DB5(DAC2_DB5), .DAC2_DB6(DAC2_DB6), .DAC2_DB7(DAC2_DB7),
    .DAC_MODE(DAC_MODE), .SKUT_MBR(SKUT_MBR), .SKUT_VI(SKUT_VI)
  );

  assign dac1 = {DAC1_DB7, DAC1_DB6, DAC1_DB5, DAC1_DB4, DAC1_DB3, DAC1_DB2, DAC1_DB1, DAC1_DB0};
  assign dac2 = {DAC2_DB7, DAC2_DB6, DAC2_DB5, DAC2_DB4, DAC2_DB3, DAC2_DB2, DAC2_DB1, DAC2_DB0};

  always #6 clk80 = ~clk80;

  // Cumulative strobe-high cycle counts; the main sequence compares deltas.
  always @(negedge clk80) begin
    if (DAC1_CLK === 1'b1) clk1_hi++;
    if (DAC2_CLK === 1'b1) clk2_hi++;
  end

  initial begin
    repeat (98000) @(posedge clk80);
    $display("FAIL watchdog: observed no end of test, expected finish before 98000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int k, input logic [7:0] b0);
    if (k == 0)  return b0;
    if (k == 13) return 8'hED;
    return 8'(5 * k);
  endfunction

  function automatic logic [7:0] slow_byte(input int slot);
    return (slot == 12) ? 8'hED : 8'(5 * (slot + 1));
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_tx"},   UART0_TX,  1'b1);
    check({tag, "_dtx"},  UART0_dTX, 1'b0);
    check({tag, "_drx"},  UART0_dRX, 1'b0);
    check({tag, "_dac1"}, dac1,      8'h00);
    check({tag, "_dac2"}, dac2,      8'h00);
    check({tag, "_clks"}, {DAC1_CLK, DAC2_CLK}, 2'b00);
    check({tag, "_mode"}, DAC_MODE,  1'b0);
    check({tag, "_mbr"},  SKUT_MBR,  1'b0);
    check({tag, "_vi"},   SKUT_VI,   1'b0);
  endtask

  // Waits for the request, decodes it mid-bit and checks the enables around it.
  task automatic get_request(input string tag);
    int waited = 0;
    logic [7:0] b;
    logic en_ok;
    while (UART0_dTX !== 1'b1 && waited < POLL + 200) begin
      @(negedge clk80);
      waited++;
    end
    check({tag, "_req_seen"}, UART0_dTX, 1'b1);
    if (UART0_dTX !== 1'b1) return;
    repeat (BAUD / 2) @(negedge clk80);
    check({tag, "_start"}, UART0_TX, 1'b0);
    en_ok = UART0_dTX & UART0_dRX;
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD) @(negedge clk80);
      b[i] = UART0_TX;
      en_ok = en_ok & UART0_dTX & UART0_dRX;
    end
    repeat (BAUD) @(negedge clk80);
    check({tag, "_stop"}, UART0_TX, 1'b1);
    en_ok = en_ok & UART0_dTX & UART0_dRX;
    check({tag, "_req_byte"}, b, 8'hA5);
    check({tag, "_en_high"}, en_ok, 1'b1);
    repeat (BAUD - BAUD / 2 + 2) @(negedge clk80);
    check({tag, "_en_low"}, {UART0_dTX, UART0_dRX}, 2'b00);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk80);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk80);
    end
    rx = stop;
    repeat (BAUD) @(negedge clk80);
    rx = 1'b1;
  endtask

  task automatic run_poll(input string tag, input logic [7:0] b0, input int bad_idx);
    get_request(tag);
    for (int k = 0; k < 14; k++) send_byte(frame_byte(k, b0), (k != bad_idx));
    repeat (40) @(negedge clk80);
  endtask

  initial begin
    int c1, c2, slot, hi;
    logic exp_vi;
    logic [7:0] b0;

    rst_n = 1'b0;
    repeat (4) @(negedge clk80);
    check_reset_state("in_rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk80);
    check_reset_state("post_rst");

    // Fourteen good polls: DAC1 follows byte 0, DAC2 rotates through bytes 1..13.
    exp_vi = 1'b0;
    slot = 0;
    for (int p = 1; p <= 14; p++) begin
      c1 = clk1_hi;
      c2 = clk2_hi;
      b0 = (p == 1) ? 8'h00 : 8'(p);
      run_poll($sformatf("p%0d", p), b0, -1);
      exp_vi = ~exp_vi;
      check($sformatf("p%0d_dac1", p), dac1, b0);
      check($sformatf("p%0d_dac2", p), dac2, slow_byte(slot));
      check($sformatf("p%0d_vi", p), SKUT_VI, exp_vi);
      check($sformatf("p%0d_mbr", p), SKUT_MBR, 1'b0);
      check($sformatf("p%0d_clk1", p), clk1_hi - c1, 2);
      check($sformatf("p%0d_clk2", p), clk2_hi - c2, 2);
      slot = (slot == 12) ? 0 : slot + 1;
    end

    // Framing error in byte 3: fault flagged, DACs and toggle untouched.
    c1 = clk1_hi;
    run_poll("ferr", 8'h99, 3);
    check("ferr_mbr", SKUT_MBR, 1'b1);
    check("ferr_dac1", dac1, 8'd14);
    check("ferr_dac2", dac2, 8'd5);
    check("ferr_vi", SKUT_VI, exp_vi);
    check("ferr_clk", clk1_hi - c1, 0);

    // Next good frame clears the fault; slot continued at 1.
    c1 = clk1_hi;
    run_poll("rec", 8'h77, -1);
    exp_vi = ~exp_vi;
    check("rec_mbr", SKUT_MBR, 1'b0);
    check("rec_dac1", dac1, 8'h77);
    check("rec_dac2", dac2, 8'd10);
    check("rec_vi", SKUT_VI, exp_vi);
    check("rec_clk", clk1_hi - c1, 2);

    // Short reply: only 10 of 14 bytes.
    get_request("short");
    for (int k = 0; k < 10; k++) send_byte(frame_byte(k, 8'h55), 1'b1);
`ifdef ASTRA_FRAME_TIMEOUT_EN
    repeat (TMO - 10 * 10 * BAUD - 30) @(negedge clk80);
    check("to_mbr_before", SKUT_MBR, 1'b0);
    repeat (60) @(negedge clk80);
    check("to_mbr_after", SKUT_MBR, 1'b1);
    check("to_dac1", dac1, 8'h77);
    check("to_dac2", dac2, 8'd10);
    get_request("to_next");
`else
    hi = 0;
    repeat (2 * POLL) begin
      @(negedge clk80);
      if (UART0_dTX !== 1'b0) hi++;
    end
    check("stall_no_req", hi, 0);
    check("stall_mbr", SKUT_MBR, 1'b0);
    check("stall_dac1", dac1, 8'h77);
`endif

    // Clean reset from a non-zero output state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk80);
    rst_n = 1'b1;
    repeat (2) @(negedge clk80);
    check_reset_state("rst2");

    run_poll("pre6", 8'h33, -1);
    check("pre6_dac1", dac1, 8'h33);
    check("pre6_dac2", dac2, 8'd5);
    check("pre6_vi", SKUT_VI, 1'b1);

    // Reset pulse in the middle of the seventh reply byte.
    get_request("mid");
    for (int k = 0; k < 6; k++) send_byte(frame_byte(k, 8'hC3), 1'b1);
    rx = 1'b0;
    repeat (4 * BAUD) @(negedge clk80);
    rst_n = 1'b0;
    repeat (3) @(negedge clk80);
    check_reset_state("mid_rst");
    rst_n = 1'b1;
    rx = 1'b1;
    for (int k = 7; k < 14; k++) send_byte(frame_byte(k, 8'hC3), 1'b1);

    c1 = clk1_hi;
    run_poll("post6", 8'h42, -1);
    check("post6_dac1", dac1, 8'h42);
    check("post6_dac2", dac2, 8'd5);
    check("post6_vi", SKUT_VI, 1'b1);
    check("post6_mbr", SKUT_MBR, 1'b0);
    check("post6_clk", clk1_hi - c1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
